uart_rx: RTL and testbench

- Serial receiver that sits directly downstream of the team's uart_tx.
- Deserialises the 1-bit-per-clock frame that uart_tx produces: start bit 0, DATA_WIDTH data bits MSB first, stop bit 1.
- Presents each byte through a one-entry valid/ready holding register.
- Flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_rx_hold.sv | 59 +++++
 rtl/uart_rx.sv | 111 +++++++++++
 tb/tb_uart_rx.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg : frame constants and FSM encoding shared by uart_tx / uart_rx
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  localparam int   DEFAULT_DATA_WIDTH = 8;
  localparam logic START_BIT          = 1'b0;
  localparam logic STOP_BIT           = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'h0,
    DATA   = 2'h1,
    STOP   = 2'h2,
    RESYNC = 2'h3
  } uart_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_rx_if.sv
//------------------------------------------------------------------------------
// uart_rx_if : byte handshake and error-pulse bundle of the UART receiver
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  frame_err;
  logic                  overrun;

  modport master (output data, valid, frame_err, overrun, input ready);
  modport slave  (input data, valid, frame_err, overrun, output ready);

endinterface : uart_rx_if

`default_nettype wire

// File: rtl/uart_rx_hold.sv
//------------------------------------------------------------------------------
// uart_rx_hold : one-entry valid/ready holding register with overrun pulse
// Revision     : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_hold #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  ready,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  output logic                  overrun
);

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  overrun_q, overrun_d;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load) begin
      // A full register only takes the new byte if the old one leaves this edge
      if (!valid_q || ready) begin
        data_d  = load_data;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data    = data_q;
  assign valid   = valid_q;
  assign overrun = overrun_q;

endmodule : uart_rx_hold

`default_nettype wire

// File: rtl/uart_rx.sv
//------------------------------------------------------------------------------
// uart_rx  : 1-bit-per-clock UART deserialiser (start 0, MSB first, stop 1)
//            UART_RX_SYNC_EN adds a 2-flop input synchroniser on rx.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic      CLK,
  input  logic      RESETN,
  input  logic      rx,
  uart_rx_if.master bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;

  assign sync_d = {sync_q[0], rx};

  // Line idles high, so the synchroniser resets to 1 to avoid a false start
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) sync_q <= 2'b11;
    else         sync_q <= sync_d;
  end

  assign rx_s = sync_q[1];
`else
  assign rx_s = rx;
`endif

  uart_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  frame_err_q, frame_err_d;
  logic                  good_frame;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    good_frame  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rx_s == START_BIT) begin
          state_d = DATA;
          cnt_d   = CNT_W'(DATA_WIDTH - 1);
        end
      end
      DATA: begin
        shift_d = {shift_q[DATA_WIDTH-2:0], rx_s};
        if (cnt_q == '0) state_d = STOP;
        else             cnt_d   = cnt_q - 1'b1;
      end
      STOP: begin
        if (rx_s == STOP_BIT) begin
          good_frame = 1'b1;
          state_d    = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = RESYNC;
        end
      end
      RESYNC: begin
        // Only a high line re-arms start detection after a broken frame
        if (rx_s == STOP_BIT) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_rx_hold #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_hold (
    .clk       (CLK),
    .rst_n     (RESETN),
    .load      (good_frame),
    .load_data (shift_q),
    .ready     (bus.ready),
    .data      (bus.data),
    .valid     (bus.valid),
    .overrun   (bus.overrun)
  );

  assign bus.frame_err = frame_err_q;

endmodule : uart_rx

`default_nettype wire

// File: tb/tb_uart_rx.sv
//------------------------------------------------------------------------------
// tb_uart_rx : directed + random frame stream against a frame-level model
// Revision   : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic CLK = 1'b0;
  logic RESETN;
  logic rx;

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8)) dut (
    .CLK    (CLK),
    .RESETN (RESETN),
    .rx     (rx),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  int vectors    = 0;
  int miscompares = 0;

  bit rx_q[$];
  bit rdy_q[$];

  bit         eff[];
  bit         good[];
  logic [7:0] gbyte[];
  bit         exp_v[];
  logic [7:0] exp_d[];
  bit         exp_fe[];
  bit         exp_ov[];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic bit fbit(input logic [7:0] b, input bit st, input int k);
    if (k == 0) return 1'b0;
    if (k == 9) return st;
    return b[8-k];
  endfunction

  task automatic add_idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) begin
      rx_q.push_back(1'b1);
      rdy_q.push_back(rdy);
    end
  endtask

  task automatic add_frame(input logic [7:0] b, input bit st, input logic [9:0] rm);
    for (int k = 0; k < 10; k++) begin
      rx_q.push_back(fbit(b, st, k));
      rdy_q.push_back(rm[k]);
    end
  endtask

  // Frame-level reference: walk the (latency-shifted) line, then apply the
  // holding-register rules cycle by cycle.
  task automatic build_model(input int n);
    int pos;
    int s;
    int val;
    bit v;
    logic [7:0] d;
    eff = new[n]; good = new[n]; gbyte = new[n];
    exp_v = new[n+1]; exp_d = new[n+1]; exp_fe = new[n+1]; exp_ov = new[n+1];
    for (int c = 0; c < n; c++) eff[c] = (c < LAT) ? 1'b1 : rx_q[c-LAT];
    pos = 0;
    while (pos < n) begin
      if (eff[pos]) pos++;
      else if (pos + 9 >= n) pos = n;
      else begin
        val = 0;
        for (int k = 1; k <= 8; k++) val = val * 2 + int'(eff[pos+k]);
        s = pos + 9;
        pos = s + 1;
        if (eff[s]) begin
          good[s]  = 1'b1;
          gbyte[s] = val[7:0];
        end else begin
          exp_fe[s+1] = 1'b1;
          while (pos < n && !eff[pos]) pos++;
          pos++;
        end
      end
    end
    v = 1'b0;
    d = 8'h00;
    for (int c = 0; c < n; c++) begin
      exp_v[c] = v;
      exp_d[c] = d;
      if (good[c]) begin
        if (!v || rdy_q[c]) begin
          d = gbyte[c];
          v = 1'b1;
        end else begin
          exp_ov[c+1] = 1'b1;
        end
      end else if (v && rdy_q[c]) begin
        v = 1'b0;
      end
    end
    exp_v[n] = v;
    exp_d[n] = d;
  endtask

  task automatic check_cycle(input int c);
    chk($sformatf("valid@%0d", c),     32'(bus.valid),     32'(exp_v[c]));
    chk($sformatf("data@%0d", c),      32'(bus.data),      32'(exp_d[c]));
    chk($sformatf("frame_err@%0d", c), 32'(bus.frame_err), 32'(exp_fe[c]));
    chk($sformatf("overrun@%0d", c),   32'(bus.overrun),   32'(exp_ov[c]));
  endtask

  initial begin
    int n;
    logic [7:0] rb;
    logic [7:0] pb;

    RESETN    = 1'b0;
    rx        = 1'b1;
    bus.ready = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    @(negedge CLK);
    RESETN = 1'b1;

    // Single frame A5
    add_idle(4, 1'b1);
    add_frame(8'hA5, 1'b1, 10'h3FF);
    add_idle(3, 1'b1);
    // Back-to-back 00, FF
    add_frame(8'h00, 1'b1, 10'h3FF);
    add_frame(8'hFF, 1'b1, 10'h3FF);
    add_idle(3, 1'b1);
    // Overrun: 3C then C3 with ready low
    add_frame(8'h3C, 1'b1, 10'h000);
    add_frame(8'hC3, 1'b1, 10'h000);
    add_idle(2, 1'b0);
    add_idle(3, 1'b1);
    // Accept and load on the same edge
    add_frame(8'h11, 1'b1, 10'h000);
    add_frame(8'h22, 1'b1, 10'h200);
    add_idle(3, 1'b1);
    // Framing error, low line, then recovery
    add_frame(8'h5A, 1'b0, 10'h3FF);
    for (int i = 0; i < 5; i++) begin
      rx_q.push_back(1'b0);
      rdy_q.push_back(1'b1);
    end
    add_idle(1, 1'b1);
    add_frame(8'h81, 1'b1, 10'h3FF);
    add_idle(3, 1'b1);
    // Random traffic
    for (int f = 0; f < 40; f++) begin
      rb = 8'($urandom);
      add_frame(rb, ($urandom_range(0, 7) != 0), 10'($urandom));
      if (rx_q[rx_q.size()-1] == 1'b0) begin
        for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
          rx_q.push_back(1'b0);
          rdy_q.push_back(1'($urandom));
        end
        add_idle(1, 1'($urandom));
      end
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) add_idle(1, 1'($urandom));
    end
    add_idle(4, 1'b1);

    n = rx_q.size();
    build_model(n);

    tick();
    for (int c = 0; c < n; c++) begin
      check_cycle(c);
      rx        = rx_q[c];
      bus.ready = rdy_q[c];
      tick();
    end
    check_cycle(n);

    // Mid-frame reset with a loaded holding register
    bus.ready = 1'b1;
    rx        = 1'b1;
    tick();
    tick();
    bus.ready = 1'b0;
    pb = 8'h99;
    for (int k = 0; k < 10; k++) begin
      rx = fbit(pb, 1'b1, k);
      tick();
    end
    rx = 1'b1;
    repeat (LAT + 1) tick();
    chk("preload_valid", 32'(bus.valid), 32'd1);
    chk("preload_data", 32'(bus.data), 32'h99);
    pb = 8'hE7;
    for (int k = 0; k < 5; k++) begin
      rx = fbit(pb, 1'b1, k);
      tick();
    end
    rx = fbit(pb, 1'b1, 5);
    #2;
    RESETN = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus.valid), 32'd0);
    chk("midrst_data", 32'(bus.data), 32'd0);
    chk("midrst_frame_err", 32'(bus.frame_err), 32'd0);
    chk("midrst_overrun", 32'(bus.overrun), 32'd0);
    rx = 1'b1;
    @(negedge CLK);
    RESETN = 1'b1;
    tick();
    tick();
    chk("postrst_valid", 32'(bus.valid), 32'd0);
    for (int t = 1; t <= 11 + LAT; t++) begin
      rx = (t - 1 < 10) ? fbit(pb, 1'b1, t - 1) : 1'b1;
      tick();
      chk($sformatf("e7_valid@%0d", t), 32'(bus.valid), 32'(t >= 10 + LAT));
      chk($sformatf("e7_frame_err@%0d", t), 32'(bus.frame_err), 32'd0);
    end
    chk("e7_data", 32'(bus.data), 32'hE7);
    bus.ready = 1'b1;
    tick();
    chk("e7_consumed", 32'(bus.valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_uart_rx

`default_nettype wire
